// File: rtl/cpu_exec_unit.sv
`timescale 1ns/1ps
// Clocked execute stage: single-cycle ALU/jump/ID/INIT ops plus an iterative
// restoring divider that holds off fetch until the quotient is resolved.
module cpu_exec_unit #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] PC_RESET = '0,
    parameter int               STEP     = 12,
    parameter logic [31:0]      CPUID    = 32'h19920308
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             enable_i,
    input  logic             fetch_valid_i,
    input  logic [WIDTH-1:0] opcode_i,
    input  logic [WIDTH-1:0] opa_i,
    input  logic [WIDTH-1:0] opb_i,
    output logic             exec_ready_o,
    output logic [WIDTH-1:0] newpc_o,
    output logic             isjcc_o,
    output logic [WIDTH-1:0] data_o,
    output logic             exec_done_o,
    output logic [1:0]       err_o
);

    localparam int               CNT_W   = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] STEP_W  = WIDTH'(STEP);
    localparam logic [WIDTH-1:0] CPUID_W = WIDTH'(CPUID);

    localparam logic [7:0] OP_ADD  = 8'h00;
    localparam logic [7:0] OP_SUB  = 8'h01;
    localparam logic [7:0] OP_MUL  = 8'h02;
    localparam logic [7:0] OP_DIV  = 8'h03;
    localparam logic [7:0] OP_DISP = 8'h04;
    localparam logic [7:0] OP_JMP  = 8'h05;
    localparam logic [7:0] OP_ID   = 8'h06;
    localparam logic [7:0] OP_INIT = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   newpc_q, newpc_d;
    logic               isjcc_q, isjcc_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic               done_q, done_d;
    logic [1:0]         err_q, err_d;

    // Divider working set: quo_q starts as the dividend and shifts into the quotient.
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   pc_q, pc_d;

    logic [WIDTH:0]     rem_shift;
    logic [WIDTH:0]     rem_diff;
    logic [WIDTH-1:0]   quo_next;
    logic [WIDTH-1:0]   rem_next;
    logic [WIDTH-1:0]   pc_step;
    logic [7:0]         op;
    logic               accept;
    logic [WIDTH-1:0]   unused_opcode;

    assign unused_opcode = opcode_i;
    assign op            = opcode_i[7:0];
    assign exec_ready_o  = (state_q == ST_IDLE) && !rst_i;
    assign accept        = fetch_valid_i && enable_i && exec_ready_o;
    assign pc_step       = newpc_q + STEP_W;

    assign newpc_o     = newpc_q;
    assign isjcc_o     = isjcc_q;
    assign data_o      = data_q;
    assign exec_done_o = done_q;
    assign err_o       = err_q;

    // One restoring step: shift in the next dividend bit, keep the difference if non-negative.
    always_comb begin
        rem_shift = {rem_q, quo_q[WIDTH-1]};
        rem_diff  = rem_shift - {1'b0, dvs_q};
        if (!rem_diff[WIDTH]) begin
            rem_next = rem_diff[WIDTH-1:0];
            quo_next = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
            rem_next = rem_shift[WIDTH-1:0];
            quo_next = {quo_q[WIDTH-2:0], 1'b0};
        end
    end

    always_comb begin
        state_d = state_q;
        newpc_d = newpc_q;
        isjcc_d = isjcc_q;
        data_d  = data_q;
        done_d  = 1'b0;
        err_d   = err_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        pc_d    = pc_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    newpc_d = pc_step;
                    isjcc_d = 1'b0;
                    err_d   = 2'b00;
                    case (op)
                        OP_ADD:  data_d = opa_i + opb_i;
                        OP_SUB:  data_d = opa_i - opb_i;
                        OP_MUL:  data_d = opa_i * opb_i;
                        OP_DIV: begin
                            if (opb_i == '0) begin
                                data_d = '1;
                                err_d  = 2'b10;
                            end else begin
                                // Outputs keep their old values until the quotient is ready.
                                state_d = ST_DIV;
                                done_d  = 1'b0;
                                newpc_d = newpc_q;
                                isjcc_d = isjcc_q;
                                err_d   = err_q;
                                quo_d   = opa_i;
                                rem_d   = '0;
                                dvs_d   = opb_i;
                                cnt_d   = CNT_W'(WIDTH);
                                pc_d    = pc_step;
                            end
                        end
                        OP_DISP: data_d = data_q;
                        OP_JMP: begin
                            newpc_d = opa_i;
                            isjcc_d = 1'b1;
                        end
                        OP_ID:   data_d = CPUID_W;
                        OP_INIT: newpc_d = PC_RESET;
                        default: err_d = 2'b01;
                    endcase
                end
            end

            ST_DIV: begin
                quo_d = quo_next;
                rem_d = rem_next;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    data_d  = quo_next;
                    newpc_d = pc_q;
                    isjcc_d = 1'b0;
                    err_d   = 2'b00;
                end
            end

            ST_DONE: state_d = ST_IDLE;

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            newpc_q <= PC_RESET;
            isjcc_q <= 1'b0;
            data_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 2'b00;
            quo_q   <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            newpc_q <= newpc_d;
            isjcc_q <= isjcc_d;
            data_q  <= data_d;
            done_q  <= done_d;
            err_q   <= err_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            pc_q    <= pc_d;
        end
    end

endmodule

// File: tb/tb_cpu_exec_unit.sv
`timescale 1ns/1ps
// Randomised self-checking bench for cpu_exec_unit (WIDTH=32) with an
// architectural reference model of PC, result, jump flag and error code.
module tb_cpu_exec_unit;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        fetch_valid;
    logic [31:0] opcode;
    logic [31:0] opa;
    logic [31:0] opb;
    logic        exec_ready;
    logic [31:0] newpc;
    logic        isjcc;
    logic [31:0] data;
    logic        exec_done;
    logic [1:0]  err;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_pc   = 32'h0;
    logic [31:0] m_data = 32'h0;
    logic        m_jcc  = 1'b0;
    logic [1:0]  m_err  = 2'b00;

    cpu_exec_unit dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .enable_i      (enable),
        .fetch_valid_i (fetch_valid),
        .opcode_i      (opcode),
        .opa_i         (opa),
        .opb_i         (opb),
        .exec_ready_o  (exec_ready),
        .newpc_o       (newpc),
        .isjcc_o       (isjcc),
        .data_o        (data),
        .exec_done_o   (exec_done),
        .err_o         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Architectural effect of one instruction; lat = edges from accept to completion.
    task automatic model_exec(input logic [31:0] op, input logic [31:0] a,
                              input logic [31:0] b, output int lat);
        logic [7:0] o;
        o      = op[7:0];
        lat    = 0;
        m_err  = 2'b00;
        m_jcc  = 1'b0;
        case (o)
            8'h00: m_data = a + b;
            8'h01: m_data = a - b;
            8'h02: m_data = a * b;
            8'h03: begin
                if (b == 0) begin
                    m_data = 32'hFFFF_FFFF;
                    m_err  = 2'b10;
                end else begin
                    m_data = a / b;
                    lat    = 32;
                end
            end
            8'h04: m_data = m_data;
            8'h05: begin
                m_pc  = a;
                m_jcc = 1'b1;
            end
            8'h06: m_data = 32'h1992_0308;
            8'hFF: m_pc = 32'h0;
            default: m_err = 2'b01;
        endcase
        if (o != 8'h05 && o != 8'hFF) m_pc = m_pc + 32'd12;
    endtask

    // Presents one instruction, waits for acceptance and completion; lat=-1 on timeout.
    task automatic run_instr(input logic [31:0] op, input logic [31:0] a,
                             input logic [31:0] b, output int lat);
        int n;
        @(negedge clk);
        opcode = op; opa = a; opb = b;
        fetch_valid = 1'b1; enable = 1'b1;
        n = 0;
        while (!exec_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!exec_ready) begin
            fetch_valid = 1'b0;
            lat = -1;
            return;
        end
        @(posedge clk); #1;
        fetch_valid = 1'b0;
        lat = 0;
        while (!exec_done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!exec_done) lat = -1;
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0; fetch_valid = 1'b0;
        opcode = '0; opa = '0; opb = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (exec_ready !== 1'b0) begin errors++; $display("FAIL rst_ready_in_reset: got %b want 0", exec_ready); end
        checks++; if (newpc !== 32'h0) begin errors++; $display("FAIL rst_pc: got %h want 0", newpc); end
        checks++; if (data !== 32'h0) begin errors++; $display("FAIL rst_data: got %h want 0", data); end
        checks++; if (isjcc !== 1'b0 || err !== 2'b00 || exec_done !== 1'b0) begin errors++; $display("FAIL rst_flags: got jcc=%b err=%b done=%b want 0/00/0", isjcc, err, exec_done); end
        @(negedge clk); rst = 1'b0; #1;
        checks++; if (exec_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_after: got %b want 1", exec_ready); end
        $display("txn reset");
    endtask

    task automatic test_add();
        int lat, exp_lat;
        model_exec(32'h0, 32'd5, 32'd7, exp_lat);
        run_instr(32'h0, 32'd5, 32'd7, lat);
        $display("txn ADD 5+7 lat=%0d data=%h pc=%h", lat, data, newpc);
        checks++; if (lat !== exp_lat) begin errors++; $display("FAIL add_latency: got %0d want %0d", lat, exp_lat); end
        checks++; if (data !== 32'd12) begin errors++; $display("FAIL add_data: got %h want 0000000c", data); end
        checks++; if (newpc !== 32'd12) begin errors++; $display("FAIL add_pc: got %h want 0000000c", newpc); end
        checks++; if (isjcc !== 1'b0 || err !== 2'b00 || exec_done !== 1'b1) begin errors++; $display("FAIL add_flags: got jcc=%b err=%b done=%b want 0/00/1", isjcc, err, exec_done); end
        @(posedge clk); #1;
        checks++; if (exec_done !== 1'b0 || exec_ready !== 1'b1) begin errors++; $display("FAIL add_after: got done=%b ready=%b want 0/1", exec_done, exec_ready); end
    endtask

    task automatic test_div();
        int n, bad, lat, exp_lat;
        logic [31:0] old_data;
        @(negedge clk);
        opcode = 32'h3; opa = 32'd100; opb = 32'd7;
        fetch_valid = 1'b1; enable = 1'b1;
        n = 0;
        while (!exec_ready && n < 100) begin @(negedge clk); n++; end
        checks++; if (exec_ready !== 1'b1) begin errors++; $display("FAIL div_accept: got ready=%b want 1", exec_ready); end
        @(posedge clk); #1;
        fetch_valid = 1'b0;
        old_data = m_data;
        model_exec(32'h3, 32'd100, 32'd7, exp_lat);
        bad = 0;
        for (int i = 1; i <= 32; i++) begin
            if (exec_ready !== 1'b0 || data !== old_data || exec_done !== 1'b0) bad++;
            @(posedge clk); #1;
        end
        $display("txn DIV 100/7 data=%h done=%b", data, exec_done);
        checks++; if (bad !== 0) begin errors++; $display("FAIL div_hold: got %0d bad cycles want 0", bad); end
        checks++; if (exec_done !== 1'b1) begin errors++; $display("FAIL div_done: got %b want 1", exec_done); end
        checks++; if (data !== 32'd14) begin errors++; $display("FAIL div_data: got %h want 0000000e", data); end
        checks++; if (newpc !== m_pc || err !== 2'b00) begin errors++; $display("FAIL div_pc_err: got pc=%h err=%b want %h/00", newpc, err, m_pc); end
        model_exec(32'h3, 32'hFFFF_FFFF, 32'd1, exp_lat);
        run_instr(32'h3, 32'hFFFF_FFFF, 32'd1, lat);
        $display("txn DIV ffffffff/1 lat=%0d data=%h", lat, data);
        checks++; if (lat !== exp_lat) begin errors++; $display("FAIL div_max_latency: got %0d want %0d", lat, exp_lat); end
        checks++; if (data !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_max_data: got %h want ffffffff", data); end
    endtask

    task automatic test_div_zero();
        int lat, exp_lat;
        model_exec(32'h3, 32'd55, 32'd0, exp_lat);
        run_instr(32'h3, 32'd55, 32'd0, lat);
        $display("txn DIV 55/0 lat=%0d data=%h err=%b pc=%h", lat, data, err, newpc);
        checks++; if (lat !== 0) begin errors++; $display("FAIL div0_latency: got %0d want 0", lat); end
        checks++; if (data !== 32'hFFFF_FFFF || err !== 2'b10) begin errors++; $display("FAIL div0_result: got data=%h err=%b want ffffffff/10", data, err); end
        checks++; if (newpc !== m_pc) begin errors++; $display("FAIL div0_pc: got %h want %h", newpc, m_pc); end
        model_exec(32'h0, 32'd1, 32'd2, exp_lat);
        run_instr(32'h0, 32'd1, 32'd2, lat);
        $display("txn ADD 1+2 err=%b", err);
        checks++; if (err !== 2'b00 || data !== 32'd3) begin errors++; $display("FAIL div0_clear: got err=%b data=%h want 00/00000003", err, data); end
    endtask

    task automatic test_jmp_id();
        int lat, exp_lat;
        model_exec(32'h5, 32'h40, 32'h1234, exp_lat);
        run_instr(32'h5, 32'h40, 32'h1234, lat);
        $display("txn JMP 40 pc=%h jcc=%b", newpc, isjcc);
        checks++; if (newpc !== 32'h40 || isjcc !== 1'b1) begin errors++; $display("FAIL jmp: got pc=%h jcc=%b want 00000040/1", newpc, isjcc); end
        model_exec(32'h6, 32'h0, 32'h0, exp_lat);
        run_instr(32'h6, 32'h0, 32'h0, lat);
        $display("txn ID pc=%h data=%h", newpc, data);
        checks++; if (newpc !== 32'h4C || isjcc !== 1'b0) begin errors++; $display("FAIL id_pc: got pc=%h jcc=%b want 0000004c/0", newpc, isjcc); end
        checks++; if (data !== 32'h1992_0308) begin errors++; $display("FAIL id_data: got %h want 19920308", data); end
    endtask

    task automatic test_illegal_init();
        int lat, exp_lat;
        logic [31:0] old_data;
        old_data = m_data;
        model_exec(32'h7A, 32'h9, 32'h9, exp_lat);
        run_instr(32'h7A, 32'h9, 32'h9, lat);
        $display("txn ILLEGAL 7a err=%b pc=%h", err, newpc);
        checks++; if (err !== 2'b01 || data !== old_data) begin errors++; $display("FAIL illegal: got err=%b data=%h want 01/%h", err, data, old_data); end
        checks++; if (newpc !== m_pc) begin errors++; $display("FAIL illegal_pc: got %h want %h", newpc, m_pc); end
        model_exec(32'hFF, 32'h0, 32'h0, exp_lat);
        run_instr(32'hFF, 32'h0, 32'h0, lat);
        $display("txn INIT pc=%h", newpc);
        checks++; if (newpc !== 32'h0 || isjcc !== 1'b0 || err !== 2'b00) begin errors++; $display("FAIL init: got pc=%h jcc=%b err=%b want 0/0/00", newpc, isjcc, err); end
    endtask

    task automatic test_disable();
        int pulses, n;
        @(negedge clk);
        n = 0;
        while (!exec_ready && n < 100) begin @(negedge clk); n++; end
        opcode = 32'h0; opa = 32'd5; opb = 32'd7;
        fetch_valid = 1'b1; enable = 1'b0;
        pulses = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (exec_done) pulses++;
        end
        fetch_valid = 1'b0; enable = 1'b1;
        $display("txn ADD disabled pulses=%0d pc=%h", pulses, newpc);
        checks++; if (pulses !== 0) begin errors++; $display("FAIL disable_pulses: got %0d want 0", pulses); end
        checks++; if (newpc !== m_pc || data !== m_data) begin errors++; $display("FAIL disable_state: got pc=%h data=%h want %h/%h", newpc, data, m_pc, m_data); end
    endtask

    task automatic test_back_to_back();
        int pulses, consec, n, exp_lat;
        logic prev;
        @(negedge clk);
        n = 0;
        while (!exec_ready && n < 100) begin @(negedge clk); n++; end
        opcode = 32'h0; opa = 32'd1; opb = 32'd1;
        fetch_valid = 1'b1; enable = 1'b1;
        pulses = 0; consec = 0; prev = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (exec_done) pulses++;
            if (exec_done && prev) consec++;
            prev = exec_done;
        end
        fetch_valid = 1'b0;
        for (int i = 0; i < 10; i++) model_exec(32'h0, 32'd1, 32'd1, exp_lat);
        $display("txn back_to_back pulses=%0d pc=%h", pulses, newpc);
        checks++; if (pulses !== 10 || consec !== 0) begin errors++; $display("FAIL b2b_rate: got pulses=%0d adjacent=%0d want 10/0", pulses, consec); end
        checks++; if (newpc !== m_pc || data !== 32'd2) begin errors++; $display("FAIL b2b_state: got pc=%h data=%h want %h/00000002", newpc, data, m_pc); end
    endtask

    task automatic test_random();
        int lat, exp_lat, r;
        logic [31:0] op, a, b, hi;
        for (int t = 0; t < 40; t++) begin
            r = $urandom_range(0, 9);
            case (r)
                7: op = 32'hFF;
                8: op = $urandom_range(7, 254);
                9: op = 32'h3;
                default: op = r;
            endcase
            hi = $urandom();
            op = (hi & 32'hFFFF_FF00) | (op & 32'hFF);
            a = $urandom();
            b = ($urandom_range(0, 1) == 1) ? $urandom() : $urandom_range(0, 300);
            model_exec(op, a, b, exp_lat);
            run_instr(op, a, b, lat);
            $display("txn rnd op=%h a=%h b=%h lat=%0d data=%h pc=%h jcc=%b err=%b", op, a, b, lat, data, newpc, isjcc, err);
            checks++; if (lat !== exp_lat) begin errors++; $display("FAIL rnd_latency: got %0d want %0d", lat, exp_lat); end
            checks++; if (data !== m_data) begin errors++; $display("FAIL rnd_data: got %h want %h", data, m_data); end
            checks++; if (newpc !== m_pc || isjcc !== m_jcc) begin errors++; $display("FAIL rnd_pc: got pc=%h jcc=%b want %h/%b", newpc, isjcc, m_pc, m_jcc); end
            checks++; if (err !== m_err) begin errors++; $display("FAIL rnd_err: got %b want %b", err, m_err); end
        end
    endtask

    task automatic test_reset_mid_div();
        int n, pulses;
        @(negedge clk);
        opcode = 32'h3; opa = 32'd1000; opb = 32'd3;
        fetch_valid = 1'b1; enable = 1'b1;
        n = 0;
        while (!exec_ready && n < 100) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        fetch_valid = 1'b0;
        pulses = 0;
        for (int i = 1; i < 10; i++) begin
            @(posedge clk); #1;
            if (exec_done) pulses++;
        end
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        if (exec_done) pulses++;
        m_pc = 32'h0; m_data = 32'h0; m_jcc = 1'b0; m_err = 2'b00;
        checks++; if (exec_ready !== 1'b0) begin errors++; $display("FAIL rstdiv_ready_in_reset: got %b want 0", exec_ready); end
        checks++; if (newpc !== m_pc || data !== m_data || isjcc !== m_jcc || err !== m_err) begin errors++; $display("FAIL rstdiv_outputs: got pc=%h data=%h jcc=%b err=%b want reset values", newpc, data, isjcc, err); end
        @(negedge clk); rst = 1'b0; #1;
        checks++; if (exec_ready !== 1'b1) begin errors++; $display("FAIL rstdiv_ready_after: got %b want 1", exec_ready); end
        repeat (40) begin
            @(posedge clk); #1;
            if (exec_done) pulses++;
        end
        $display("txn DIV aborted by reset pulses=%0d", pulses);
        checks++; if (pulses !== 0) begin errors++; $display("FAIL rstdiv_pulses: got %0d want 0", pulses); end
        checks++; if (data !== 32'h0 || newpc !== 32'h0) begin errors++; $display("FAIL rstdiv_hold: got pc=%h data=%h want 0/0", newpc, data); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_div();
        test_div_zero();
        test_jmp_id();
        test_illegal_init();
        test_disable();
        test_back_to_back();
        test_random();
        test_reset_mid_div();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cpu_exec_unit.md
# cpu_exec_unit

Clocked, parametrised successor to the combinational decode/execute stage. It sits between the fetch stage and the PC/result consumers. It accepts one instruction per valid/ready handshake and executes single-cycle ALU, jump, ID and init operations. Divides run on an iterative restoring divider, so the unit stalls fetch for the divide's duration. It also reports illegal-opcode and divide-by-zero errors.

## Interface
- WIDTH, 32, datapath, PC and operand width (>= 8)
- PC_RESET, 0, PC value after reset and after the INIT opcode
- STEP, 12, PC increment for every non-jump instruction
- CPUID, 32'h19920308, value returned by the ID opcode, truncated to WIDTH
- clk_i  in  1  clock; everything is sampled on the rising edge
- rst_i  in  1  reset; synchronous, active-high
- enable_i  in  1  unit enable; qualifies acceptance only
- fetch_valid_i  in  1  opcode_i, opa_i and opb_i are valid
- opcode_i  in  WIDTH  instruction word; only [7:0] is decoded
- opa_i  in  WIDTH  operand A
- opb_i  in  WIDTH  operand B
- exec_ready_o  out  1  unit can accept an instruction this cycle
- newpc_o  out  WIDTH  PC after the last completed instruction
- isjcc_o  out  1  last completed instruction was a jump
- data_o  out  WIDTH  result register
- exec_done_o  out  1  one-cycle completion pulse
- err_o  out  2  bit0 illegal opcode, bit1 divide by zero; describes the last completed instruction

## Operation
- States: IDLE, DIV, DONE.
- exec_ready_o = (state==IDLE) && !rst_i.
- Accept happens at an edge where fetch_valid_i && enable_i && exec_ready_o.
- Opcodes [7:0]:
  - 00 ADD: data = opa+opb, mod 2^WIDTH.
  - 01 SUB: data = opa-opb, mod 2^WIDTH.
  - 02 MUL: data = low WIDTH bits of opa*opb.
  - 03 DIV: data = unsigned quotient opa/opb.
  - 04 DISPLAY: data unchanged.
  - 05 JMP: newpc = opa, isjcc = 1.
  - 06 ID: data = CPUID.
  - FF INIT: newpc = PC_RESET, data unchanged.
- Every opcode except JMP and INIT: newpc = newpc+STEP (mod 2^WIDTH), isjcc = 0. INIT also sets isjcc = 0.
- Any other opcode is illegal:
  - err = 2'b01, data unchanged, newpc += STEP, isjcc = 0.
- Single-cycle opcodes (all except DIV with opb≠0):
  - newpc_o, isjcc_o, data_o and err_o are updated on the accept edge.
  - Next state is DONE.
- DIV with opb = 0:
  - data = all ones, err = 2'b10, newpc += STEP.
  - Handled as a single-cycle opcode.
- DIV with opb ≠ 0:
  - On the accept edge: latch dividend, divisor and PC; clear the remainder; load the bit counter with WIDTH; go to DIV.
  - Each DIV cycle resolves one quotient bit, MSB first.
  - While in DIV, all outputs hold their previous values.
  - The edge on which the last bit resolves writes data_o, newpc_o, isjcc_o = 0 and err_o = 0, then goes to DONE.
- DONE: exec_done_o = 1 for exactly one cycle, then the unit returns to IDLE.
- err_o is rewritten on every completion: 00 unless the completing instruction is illegal or a divide by zero.
- enable_i and fetch_valid_i are ignored outside IDLE. Dropping enable_i mid-divide does not abort it.

## Timing
- Reset (rst_i high at an edge):
  - state = IDLE, newpc_o = PC_RESET, isjcc_o = 0, data_o = 0, exec_done_o = 0, err_o = 0, divider cleared.
  - exec_ready_o is 0 while rst_i is high and 1 in the first cycle after it falls.
- Reset overrides everything, including mid-DIV and in DONE. An aborted instruction never completes.
- Single-cycle op accepted at edge T: outputs valid and exec_done_o = 1 in cycle T+1; exec_ready_o = 1 again in cycle T+2. Maximum rate is one instruction per 2 cycles.
- DIV (opb≠0) accepted at edge T: DIV occupies cycles T+1..T+WIDTH; outputs valid and exec_done_o = 1 in cycle T+WIDTH+1; ready again in cycle T+WIDTH+2.
- Outputs are stable from completion until the next completion or reset.
- fetch_valid_i held high continuously: a new instruction is accepted every time exec_ready_o is 1. Fetch must hold its operands stable until acceptance.

## Test plan
- Reset, then ADD with opa=5, opb=7 accepted at T → cycle T+1: data_o=12, newpc_o=12, isjcc_o=0, err_o=0, exec_done_o=1. Cycle T+2: exec_done_o=0, exec_ready_o=1.
- DIV with opa=100, opb=7 accepted at T (WIDTH=32):
  - Cycles T+1..T+32: exec_ready_o=0 and data_o unchanged.
  - Cycle T+33: data_o=14, exec_done_o=1.
  - Also check 0xFFFFFFFF/1 → 0xFFFFFFFF.
- DIV with opb=0 → cycle T+1: data_o=0xFFFFFFFF, err_o=2'b10, newpc_o += 12. The next ADD clears err_o to 0.
- JMP with opa=0x40 → newpc_o=0x40, isjcc_o=1. Following ID → newpc_o=0x4C, isjcc_o=0, data_o=0x19920308.
- Opcode 0x7A → err_o=2'b01, data_o unchanged, newpc_o += 12. INIT (0xFF) → newpc_o=0, isjcc_o=0.
- Start a DIV, then assert rst_i at T+10 → no exec_done_o pulse, all outputs at reset values, exec_ready_o=1 the cycle after rst_i falls.
- Repeat the ADD case with enable_i=0 and fetch_valid_i=1 → nothing is accepted and no pulse occurs.
